// File: rtl/cluster_stats.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_stats
//  Purpose  : Per-cluster statistics for a labelled 3-D point stream.
//             Accumulates point count and per-axis bounding box for up to
//             16 cluster labels. On an end-of-frame pulse, emits one
//             summary record per occupied label in ascending label order,
//             then clears all occupancy for the next frame.
//  Ports    : clk                     - single clock, rising edge
//             rst                     - asynchronous reset, active low
//             in_x/in_y/in_z [7:0]    - point coordinates
//             in_label [3:0]          - cluster label of the point
//             in_valid                - point qualifier
//             in_done                 - end-of-frame pulse
//             in_ready                - high while points are accepted
//             out_label/out_count     - reported label and point count
//             out_{x,y,z}{min,max}    - bounding box of that cluster
//             out_valid/out_ready     - record handshake
//             out_last                - final record of the frame
//             frame_end               - one-cycle pulse when drain completes
//  Revision : 1.0 - initial release
// ============================================================================
module cluster_stats #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_x,
    input  logic [7:0]    in_y,
    input  logic [7:0]    in_z,
    input  logic [3:0]    in_label,
    input  logic          in_valid,
    input  logic          in_done,
    output logic          in_ready,
    output logic [3:0]    out_label,
    output logic [CW-1:0] out_count,
    output logic [7:0]    out_xmin,
    output logic [7:0]    out_xmax,
    output logic [7:0]    out_ymin,
    output logic [7:0]    out_ymax,
    output logic [7:0]    out_zmin,
    output logic [7:0]    out_zmax,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          frame_end
);

    localparam logic [0:0] S_ACC   = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;

    // Entry storage; only the occupancy bits need a reset value.
    logic [15:0]   r_occ;
    logic [CW-1:0] r_cnt  [16];
    logic [7:0]    r_xmin [16];
    logic [7:0]    r_xmax [16];
    logic [7:0]    r_ymin [16];
    logic [7:0]    r_ymax [16];
    logic [7:0]    r_zmin [16];
    logic [7:0]    r_zmax [16];

    // Scan pointer; bit 4 set means every index has been visited.
    logic [4:0]    r_idx;
    logic [3:0]    w_cur;
    logic [15:0]   w_above;
    logic          w_none_above;
    logic          w_accept;
    logic          w_slot_free;
    logic          w_load;
    logic          w_skip;
    logic          w_finish;

    assign in_ready     = (r_state == S_ACC);
    assign w_accept     = (r_state == S_ACC) && in_valid;
    assign w_cur        = r_idx[3:0];
    // Occupancy strictly above the current index; empty means this record is the last.
    assign w_above      = (r_occ >> w_cur) >> 1;
    assign w_none_above = (w_above == 16'd0);
    // The output register can take a new value when empty or being handshaken.
    assign w_slot_free  = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_skip      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_ACC: begin
                if (in_done) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid && out_ready && out_last) begin
                    w_finish = 1'b1;
                end else if (w_slot_free) begin
                    if (r_idx[4]) begin
                        w_finish = 1'b1;
                    end else if (r_occ[w_cur]) begin
                        w_load = 1'b1;
                    end else begin
                        w_skip = 1'b1;
                    end
                end
                if (w_finish) begin
                    w_state_nxt = S_ACC;
                end
            end
            default: w_state_nxt = S_ACC;
        endcase
    end

    // Control, occupancy and the registered output record.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ     <= 16'd0;
            r_idx     <= 5'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_end <= 1'b0;
            out_label <= 4'd0;
            out_count <= '0;
            out_xmin  <= 8'd0;
            out_xmax  <= 8'd0;
            out_ymin  <= 8'd0;
            out_ymax  <= 8'd0;
            out_zmin  <= 8'd0;
            out_zmax  <= 8'd0;
        end else begin
            frame_end <= 1'b0;
            if (r_state == S_ACC) begin
                r_idx <= 5'd0;
                if (w_accept) begin
                    r_occ[in_label] <= 1'b1;
                end
            end
            if (w_load) begin
                out_valid <= 1'b1;
                out_last  <= w_none_above;
                out_label <= w_cur;
                out_count <= r_cnt[w_cur];
                out_xmin  <= r_xmin[w_cur];
                out_xmax  <= r_xmax[w_cur];
                out_ymin  <= r_ymin[w_cur];
                out_ymax  <= r_ymax[w_cur];
                out_zmin  <= r_zmin[w_cur];
                out_zmax  <= r_zmax[w_cur];
                r_idx     <= r_idx + 5'd1;
            end else if (w_skip) begin
                // Either nothing was shown or the shown record just handshook.
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                r_idx     <= r_idx + 5'd1;
            end
            if (w_finish) begin
                r_occ     <= 16'd0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                frame_end <= 1'b1;
            end
        end
    end

    // Entry update. The occupancy bit decides between initialising and
    // merging, so stale min/max from an earlier frame are never used.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (!r_occ[in_label]) begin
                r_cnt[in_label]  <= CW'(1);
                r_xmin[in_label] <= in_x;
                r_xmax[in_label] <= in_x;
                r_ymin[in_label] <= in_y;
                r_ymax[in_label] <= in_y;
                r_zmin[in_label] <= in_z;
                r_zmax[in_label] <= in_z;
            end else begin
                if (r_cnt[in_label] != {CW{1'b1}}) begin
                    r_cnt[in_label] <= r_cnt[in_label] + CW'(1);
                end
                if (in_x < r_xmin[in_label]) r_xmin[in_label] <= in_x;
                if (in_x > r_xmax[in_label]) r_xmax[in_label] <= in_x;
                if (in_y < r_ymin[in_label]) r_ymin[in_label] <= in_y;
                if (in_y > r_ymax[in_label]) r_ymax[in_label] <= in_y;
                if (in_z < r_zmin[in_label]) r_zmin[in_label] <= in_z;
                if (in_z > r_zmax[in_label]) r_zmax[in_label] <= in_z;
            end
        end
    end

endmodule
`default_nettype wire
